// File: rtl/rs232_rx_fifo.sv
// rs232_rx_fifo: receive-side byte buffer between the RS-232 receiver and the
// CPU IO bus. A three-state drain FSM acknowledges each received byte and
// pushes it into a 2^DEPTH_LOG2 deep first-word-fall-through FIFO. Overflow
// sets a sticky overrun bit.
// Optional feature macro: RS232_RTS_FLOW_EN enables RTS flow control with
// hysteresis. Without it, rts_n is tied low.
module rs232_rx_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int RTS_MARGIN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_rdy,
  output logic                  rx_done,
  output logic [7:0]            cpu_data,
  output logic                  cpu_rdy,
  input  logic                  cpu_done,
  output logic [DEPTH_LOG2+1:0] status,
  input  logic                  ovr_clr,
  output logic                  rts_n
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] L_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACK    = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overrun;

  logic w_capture;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_discard;

  // A pop frees a slot in the same cycle, so a capture at full is still accepted
  assign w_full    = (r_count == L_DEPTH);
  assign w_pop     = cpu_done && (r_count != '0);
  assign w_push    = w_capture && (!w_full || w_pop);
  assign w_discard = w_capture && w_full && !w_pop;

  // Drain FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Drain FSM next state; SETTLE ignores rx_rdy while the receiver drops rdy
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    rx_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (rx_rdy) begin
          w_capture    = 1'b1;
          w_state_next = S_ACK;
        end
      end
      S_ACK: begin
        rx_done      = 1'b1;
        w_state_next = S_SETTLE;
      end
      S_SETTLE: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Storage array write; contents are deliberately left uninitialised on reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= rx_data;
  end

  // Pointers and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Sticky overrun; a discard in the same cycle as a clear wins
  always_ff @(posedge clk) begin
    if (rst)            r_overrun <= 1'b0;
    else if (w_discard) r_overrun <= 1'b1;
    else if (ovr_clr)   r_overrun <= 1'b0;
  end

  assign cpu_rdy  = (r_count != '0);
  assign cpu_data = cpu_rdy ? r_mem[r_rptr] : 8'h00;
  assign status   = {r_overrun, r_count};

`ifdef RS232_RTS_FLOW_EN
  localparam logic [DEPTH_LOG2:0] L_MARGIN = RTS_MARGIN[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] L_RTS_HI = L_DEPTH - L_MARGIN;
  localparam logic [DEPTH_LOG2:0] L_HALF   = {2'b01, {(DEPTH_LOG2-1){1'b0}}};

  logic r_rts_n;

  // RTS hysteresis: stop the sender near full, release once half drained
  always_ff @(posedge clk) begin
    if (rst)                      r_rts_n <= 1'b0;
    else if (r_count >= L_RTS_HI) r_rts_n <= 1'b1;
    else if (r_count <= L_HALF)   r_rts_n <= 1'b0;
  end

  assign rts_n = r_rts_n;
`else
  assign rts_n = 1'b0;
`endif

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Testbench for rs232_rx_fifo. The driver pushes each accepted byte into an
// expected-data queue; a negedge monitor pops and compares whenever the CPU
// side performs a pop. Register checks are made #1 after the rising edge.
module tb_rs232_rx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_rdy = 1'b0;
  logic       rx_done;
  logic [7:0] cpu_data;
  logic       cpu_rdy;
  logic       cpu_done = 1'b0;
  logic [5:0] status;
  logic       ovr_clr = 1'b0;
  logic       rts_n;

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  logic [7:0] exp_q [$];

  rs232_rx_fifo #(.DEPTH_LOG2(4), .RTS_MARGIN(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_rdy   (rx_rdy),
    .rx_done  (rx_done),
    .cpu_data (cpu_data),
    .cpu_rdy  (cpu_rdy),
    .cpu_done (cpu_done),
    .status   (status),
    .ovr_clr  (ovr_clr),
    .rts_n    (rts_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every CPU pop must deliver the oldest expected byte
  always @(negedge clk) begin
    if (!rst && cpu_done && cpu_rdy) begin
      if (exp_q.size() == 0) begin
        check("pop_unexpected", 32'(cpu_data), 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        $display("[TB] pop data=%02h expected=%02h", cpu_data, e);
        check("pop_data", 32'(cpu_data), 32'(e));
      end
    end
  end

  // Count acknowledge pulses seen by the receiver
  always @(negedge clk) begin
    if (rx_done) n_done++;
  end

  // Present one byte as the receiver would; optionally pop in the capture cycle
  task automatic send(input logic [7:0] b, input bit accept, input bit with_pop);
    int t;
    rx_data = b;
    rx_rdy  = 1'b1;
    if (with_pop) cpu_done = 1'b1;
    tick();
    cpu_done = 1'b0;
    if (accept) begin
      exp_q.push_back(b);
      check("latency_cpu_rdy", 32'(cpu_rdy), 32'd1);
    end
    t = 0;
    while (!rx_done && t < 8) begin
      tick();
      t++;
    end
    if (!rx_done) check("rx_done_timeout", 32'(rx_done), 32'd1);
    tick();
    rx_rdy = 1'b0;
    tick();
    $display("[TB] send data=%02h accept=%0d status=%02h", b, accept, status);
  endtask

  task automatic pop_n(input int n);
    cpu_done = 1'b1;
    repeat (n) tick();
    cpu_done = 1'b0;
  endtask

  initial begin
    int d0;
    // Reset state
    repeat (3) tick();
    check("rst_rx_done", 32'(rx_done), 32'd0);
    check("rst_cpu_rdy", 32'(cpu_rdy), 32'd0);
    check("rst_cpu_data", 32'(cpu_data), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_rts_n", 32'(rts_n), 32'd0);
    rst = 1'b0;
    tick();

    // Single byte
    d0 = n_done;
    send(8'h41, 1'b1, 1'b0);
    check("single_done_pulses", 32'(n_done - d0), 32'd1);
    check("single_cpu_rdy", 32'(cpu_rdy), 32'd1);
    check("single_cpu_data", 32'(cpu_data), 32'h41);
    check("single_status", 32'(status), 32'h01);
    pop_n(1);
    check("single_pop_rdy", 32'(cpu_rdy), 32'd0);
    check("single_pop_data", 32'(cpu_data), 32'd0);

    // Fill and wrap
    for (int i = 0; i < 16; i++) send(8'(i), 1'b1, 1'b0);
    check("fill_status16", 32'(status), 32'h10);
    pop_n(8);
    check("fill_status8", 32'(status), 32'h08);
    for (int i = 16; i < 24; i++) send(8'(i), 1'b1, 1'b0);
    check("wrap_status16", 32'(status), 32'h10);
    pop_n(16);
    check("wrap_status0", 32'(status), 32'h00);

    // Overflow
    for (int i = 0; i < 16; i++) send(8'h80 + 8'(i), 1'b1, 1'b0);
    check("ovf_full", 32'(status), 32'h10);
    send(8'hEE, 1'b0, 1'b0);
    check("ovf_overrun", 32'(status), 32'h30);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovf_clear", 32'(status), 32'h10);

    // Simultaneous push and pop at full
    send(8'hA5, 1'b1, 1'b1);
    check("simul_status", 32'(status), 32'h10);
    pop_n(16);
    check("drain_status", 32'(status), 32'h00);
    pop_n(1);
    check("empty_pop_status", 32'(status), 32'h00);
    check("empty_pop_rdy", 32'(cpu_rdy), 32'd0);
    check("empty_pop_data", 32'(cpu_data), 32'd0);

    // Reset while in ACK; the held byte is captured again afterwards
    rx_data = 8'hC3;
    rx_rdy  = 1'b1;
    tick();
    check("ack_rx_done", 32'(rx_done), 32'd1);
    rst = 1'b1;
    tick();
    check("rstack_rx_done", 32'(rx_done), 32'd0);
    check("rstack_status", 32'(status), 32'h00);
    check("rstack_cpu_rdy", 32'(cpu_rdy), 32'd0);
    exp_q.delete();
    rst = 1'b0;
    tick();
    exp_q.push_back(8'hC3);
    check("recap_cpu_rdy", 32'(cpu_rdy), 32'd1);
    check("recap_cpu_data", 32'(cpu_data), 32'hC3);
    check("recap_rx_done", 32'(rx_done), 32'd1);
    tick();
    rx_rdy = 1'b0;
    tick();
    pop_n(1);
    check("recap_drain", 32'(status), 32'h00);

`ifdef RS232_RTS_FLOW_EN
    for (int i = 0; i < 11; i++) send(8'h30 + 8'(i), 1'b1, 1'b0);
    check("rts_at11", 32'(rts_n), 32'd0);
    send(8'h3B, 1'b1, 1'b0);
    check("rts_at12", 32'(rts_n), 32'd1);
    pop_n(3);
    tick();
    check("rts_at9", 32'(rts_n), 32'd1);
    pop_n(1);
    tick();
    check("rts_at8", 32'(rts_n), 32'd0);
    pop_n(8);
    check("rts_drain", 32'(status), 32'h00);
`else
    send(8'h5A, 1'b1, 1'b0);
    check("rts_tied", 32'(rts_n), 32'd0);
    pop_n(1);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
